win_scan_ctrl: RTL and testbench

Sequential win checker for the Connect 4 board. Replaces the wide combinational neighbour checks in the placement path. After a token is placed, it walks the board through a single synchronous read port, one cell at a time, in four directions. It reports win/no-win with a one-cycle done pulse. It sits between the turn FSM (check_win states) and the board storage, which is a 42-entry x 2-bit RAM at addr = row*7 + col, with row 0 at the top and row 5 at the bottom.

---
 rtl/win_scan_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_win_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_scan_ctrl.sv
// Sequential Connect 4 win checker: walks the board through one synchronous read
// port, cell by cell, in four directions around the placed token.
module win_scan_ctrl #(
   parameter int ROWS    = 6,
   parameter int COLS    = 7,
   parameter int WIN_LEN = 4
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       start,
   input  logic [2:0] row,
   input  logic [2:0] col,
   input  logic [1:0] player,
   output logic       rd_en,
   output logic [5:0] rd_addr,
   input  logic [1:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       win,
   output logic [1:0] win_dir
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      STEP     = 3'd1,
      WAIT     = 3'd2,
      HALF_END = 3'd3,
      FINISH   = 3'd4
   } state_t;

   localparam logic [2:0]        ROW_LIM    = 3'(ROWS);
   localparam logic [2:0]        COL_LIM    = 3'(COLS);
   localparam logic signed [4:0] ROW_LIM_S  = 5'(ROWS);
   localparam logic signed [4:0] COL_LIM_S  = 5'(COLS);
   localparam logic [5:0]        COLS_W     = 6'(COLS);
   localparam logic [3:0]        WIN_LEN_W  = 4'(WIN_LEN);
   localparam logic [1:0]        K_LAST     = 2'(WIN_LEN - 1);

   state_t            state_r, state_nx_s;
   logic [2:0]        row_r, row_nx_s;
   logic [2:0]        col_r, col_nx_s;
   logic [1:0]        player_r, player_nx_s;
   logic [1:0]        dir_r, dir_nx_s;
   logic              sgn_r, sgn_nx_s;         // 1 = walking the minus sense
   logic [1:0]        k_r, k_nx_s;
   logic [2:0]        count_r, count_nx_s;
   logic              win_r, win_nx_s;
   logic [1:0]        win_dir_r, win_dir_nx_s;

   logic              rd_en_r;
   logic [5:0]        rd_addr_r;
   logic              busy_r;
   logic              done_r;

   logic signed [4:0] k_ext_s;
   logic signed [4:0] step_row_s, step_col_s;
   logic signed [4:0] tgt_row_s, tgt_col_s;
   logic              tgt_inb_s;
   logic [5:0]        tgt_addr_s;
   logic              read_go_s;

   function automatic logic signed [4:0] dir_dr(input logic [1:0] d);
      logic signed [4:0] v;
      case (d)
         2'd0:    v = 5'sd0;
         2'd1:    v = 5'sd1;
         2'd2:    v = -5'sd1;
         2'd3:    v = 5'sd1;
         default: v = 5'sd0;
      endcase
      return v;
   endfunction

   function automatic logic signed [4:0] dir_dc(input logic [1:0] d);
      logic signed [4:0] v;
      case (d)
         2'd0:    v = 5'sd1;
         2'd1:    v = 5'sd0;
         2'd2:    v = 5'sd1;
         2'd3:    v = 5'sd1;
         default: v = 5'sd0;
      endcase
      return v;
   endfunction

   // Next walk target, taken from next-cycle registers so the read strobe can be registered
   always_comb begin
      k_ext_s    = $signed({3'b000, k_nx_s});
      step_row_s = dir_dr(dir_nx_s) * k_ext_s;
      step_col_s = dir_dc(dir_nx_s) * k_ext_s;
      if (sgn_nx_s) begin
         tgt_row_s = $signed({2'b00, row_nx_s}) - step_row_s;
         tgt_col_s = $signed({2'b00, col_nx_s}) - step_col_s;
      end else begin
         tgt_row_s = $signed({2'b00, row_nx_s}) + step_row_s;
         tgt_col_s = $signed({2'b00, col_nx_s}) + step_col_s;
      end
      // five signed bits hold 8 and 9 without wrapping into the board
      tgt_inb_s  = (tgt_row_s >= 5'sd0) && (tgt_row_s < ROW_LIM_S) &&
                   (tgt_col_s >= 5'sd0) && (tgt_col_s < COL_LIM_S);
      tgt_addr_s = ({3'b000, tgt_row_s[2:0]} * COLS_W) + {3'b000, tgt_col_s[2:0]};
      read_go_s  = (state_nx_s == STEP) && tgt_inb_s;
   end

   // Scan sequencing: next state and next values of the walk registers
   always_comb begin
      state_nx_s   = state_r;
      row_nx_s     = row_r;
      col_nx_s     = col_r;
      player_nx_s  = player_r;
      dir_nx_s     = dir_r;
      sgn_nx_s     = sgn_r;
      k_nx_s       = k_r;
      count_nx_s   = count_r;
      win_nx_s     = win_r;
      win_dir_nx_s = win_dir_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               row_nx_s     = row;
               col_nx_s     = col;
               player_nx_s  = player;
               dir_nx_s     = 2'd0;
               sgn_nx_s     = 1'b0;
               k_nx_s       = 2'd1;
               count_nx_s   = 3'd1;
               win_nx_s     = 1'b0;
               win_dir_nx_s = 2'd0;
               if ((row >= ROW_LIM) || (col >= COL_LIM) || (player == 2'b00)) begin
                  state_nx_s = FINISH;
               end else begin
                  state_nx_s = STEP;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         STEP: begin
            if (rd_en_r) begin
               state_nx_s = WAIT;
            end else begin
               state_nx_s = HALF_END;
            end
         end
         WAIT: begin
            if (rd_data == player_r) begin
               if (({1'b0, count_r} + 4'd1) >= WIN_LEN_W) begin
                  win_nx_s     = 1'b1;
                  win_dir_nx_s = dir_r;
                  state_nx_s   = FINISH;
               end else begin
                  count_nx_s = count_r + 3'd1;
                  if (k_r == K_LAST) begin
                     state_nx_s = HALF_END;
                  end else begin
                     k_nx_s     = k_r + 2'd1;
                     state_nx_s = STEP;
                  end
               end
            end else begin
               state_nx_s = HALF_END;
            end
         end
         HALF_END: begin
            if (!sgn_r) begin
               sgn_nx_s   = 1'b1;
               k_nx_s     = 2'd1;
               state_nx_s = STEP;
            end else if (dir_r == 2'd3) begin
               state_nx_s = FINISH;
            end else begin
               dir_nx_s   = dir_r + 2'd1;
               sgn_nx_s   = 1'b0;
               k_nx_s     = 2'd1;
               count_nx_s = 3'd1;
               state_nx_s = STEP;
            end
         end
         FINISH: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State and walk registers
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_r   <= IDLE;
         row_r     <= 3'd0;
         col_r     <= 3'd0;
         player_r  <= 2'd0;
         dir_r     <= 2'd0;
         sgn_r     <= 1'b0;
         k_r       <= 2'd1;
         count_r   <= 3'd1;
         win_r     <= 1'b0;
         win_dir_r <= 2'd0;
      end else begin
         state_r   <= state_nx_s;
         row_r     <= row_nx_s;
         col_r     <= col_nx_s;
         player_r  <= player_nx_s;
         dir_r     <= dir_nx_s;
         sgn_r     <= sgn_nx_s;
         k_r       <= k_nx_s;
         count_r   <= count_nx_s;
         win_r     <= win_nx_s;
         win_dir_r <= win_dir_nx_s;
      end
   end

   // Registered status and read-port outputs, aligned with the state they belong to
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         rd_en_r   <= 1'b0;
         rd_addr_r <= 6'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         rd_en_r   <= read_go_s;
         rd_addr_r <= read_go_s ? tgt_addr_s : 6'd0;
         busy_r    <= (state_nx_s != IDLE);
         done_r    <= (state_nx_s == FINISH);
      end
   end

   assign rd_en   = rd_en_r;
   assign rd_addr = rd_addr_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign win     = win_r;
   assign win_dir = win_dir_r;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Bench for win_scan_ctrl: directed board table plus random boards checked against
// a loop-based reference of the scan rules, with a synchronous board RAM model.
module tb_win_scan_ctrl;

   logic       Clock = 1'b0;
   logic       Resetn;
   logic       start;
   logic [2:0] row;
   logic [2:0] col;
   logic [1:0] player;
   logic       rd_en;
   logic [5:0] rd_addr;
   logic [1:0] rd_data = 2'd0;
   logic       busy;
   logic       done;
   logic       win;
   logic [1:0] win_dir;

   logic [1:0] board [0:41];

   int total = 0;
   int bad   = 0;

   logic [5:0] got_q[$];
   int         got_cyc;
   logic       got_win;
   logic [1:0] got_dir;
   bit         busy_ok, tail_ok;

   int exp_q[$];
   int exp_cyc;
   bit exp_win;
   int exp_dir;

   typedef struct {
      logic [2:0]  r;
      logic [2:0]  c;
      logic [1:0]  p;
      logic [23:0] cells;
      int          ncells;
      logic [1:0]  val;
      bit          dup;
      bit          ew;
      logic [1:0]  ed;
      int          ecyc;
      int          enrd;
      logic [5:0]  efirst;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   logic [2:0] r_rnd, c_rnd;
   logic [1:0] p_rnd;
   int         v_rnd;
   int         n_wait;
   bit         quiet_ok;

   win_scan_ctrl dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .start   (start),
      .row     (row),
      .col     (col),
      .player  (player),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .busy    (busy),
      .done    (done),
      .win     (win),
      .win_dir (win_dir)
   );

   always #5 Clock = ~Clock;

   // board RAM: data valid the cycle after the strobe
   always @(posedge Clock) begin
      if (rd_en) rd_data <= board[rd_addr];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
      end
   endtask

   task automatic clear_board();
      for (int i = 0; i < 42; i++) board[i] = 2'd0;
   endtask

   function automatic int dr_of(input int d);
      case (d)
         0: return 0;
         1: return 1;
         2: return -1;
         default: return 1;
      endcase
   endfunction

   function automatic int dc_of(input int d);
      case (d)
         1: return 0;
         default: return 1;
      endcase
   endfunction

   // Reference: reads issued, result, and cycles from the start edge to the done cycle
   function automatic void ref_scan(input int r, input int c, input int p);
      int run, tr, tc;
      exp_q.delete();
      exp_cyc = 0;
      exp_win = 1'b0;
      exp_dir = 0;
      if (r > 5 || c > 6 || p == 0) return;
      for (int d = 0; d < 4; d++) begin
         run = 1;
         for (int s = 1; s >= -1; s -= 2) begin
            for (int k = 1; k <= 3; k++) begin
               tr = r + s * dr_of(d) * k;
               tc = c + s * dc_of(d) * k;
               if (tr < 0 || tr > 5 || tc < 0 || tc > 6) begin
                  exp_cyc += 2;
                  break;
               end
               exp_q.push_back(tr * 7 + tc);
               if (int'(board[tr * 7 + tc]) != p) begin
                  exp_cyc += 3;
                  break;
               end
               run++;
               exp_cyc += 2;
               if (run >= 4) begin
                  exp_win = 1'b1;
                  exp_dir = d;
                  return;
               end
               if (k == 3) exp_cyc += 1;
            end
         end
      end
   endfunction

   task automatic run_scan(input logic [2:0] r, input logic [2:0] c, input logic [1:0] p, input bit dup);
      got_q.delete();
      got_cyc = -1;
      got_win = 1'b0;
      got_dir = 2'd0;
      busy_ok = 1'b1;
      tail_ok = 1'b1;
      row = r; col = c; player = p; start = 1'b1;
      @(posedge Clock); #1;
      start = dup;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (cyc == 1) start = 1'b0;
         if (rd_en === 1'b1) got_q.push_back(rd_addr);
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            got_cyc = cyc;
            got_win = win;
            got_dir = win_dir;
            break;
         end
         @(posedge Clock); #1;
      end
      start = dup;
      @(posedge Clock); #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (done !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) tail_ok = 1'b0;
         @(posedge Clock); #1;
      end
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, ".done_cycle"}, got_cyc, exp_cyc);
      chk({tag, ".win"}, got_win, exp_win);
      if (exp_win) chk({tag, ".win_dir"}, got_dir, exp_dir);
      chk({tag, ".nreads"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("%s.addr%0d", tag, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, exp_q[i]);
      chk({tag, ".busy_during_scan"}, busy_ok, 1);
      chk({tag, ".idle_after_done"}, tail_ok, 1);
      chk({tag, ".win_held"}, win, exp_win);
   endtask

   initial begin
      //            r     c     p     cells                              n  val   dup   ew    ed    cyc nrd first
      vecs[0] = '{3'd5, 3'd3, 2'd1, 24'd0,                             0, 2'd0, 1'b0, 1'b0, 2'd0, 21, 5, 6'd39};
      vecs[1] = '{3'd5, 3'd3, 2'd1, {6'd0, 6'd37, 6'd36, 6'd35},       3, 2'd1, 1'b0, 1'b1, 2'd0,  9, 4, 6'd39};
      vecs[2] = '{3'd2, 3'd6, 2'd2, {6'd0, 6'd41, 6'd34, 6'd27},       3, 2'd2, 1'b0, 1'b1, 2'd1, 11, 4, 6'd19};
      vecs[3] = '{3'd2, 3'd3, 2'd1, {6'd0, 6'd23, 6'd29, 6'd35},       3, 2'd1, 1'b0, 1'b1, 2'd2, 21, 8, 6'd18};
      vecs[4] = '{3'd2, 3'd3, 2'd2, {6'd0, 6'd23, 6'd29, 6'd35},       3, 2'd1, 1'b0, 1'b0, 2'd0, 24, 8, 6'd18};
      vecs[5] = '{3'd2, 3'd0, 2'd2, {6'd0, 6'd38, 6'd30, 6'd22},       3, 2'd2, 1'b0, 1'b1, 2'd3, 22, 7, 6'd15};
      vecs[6] = '{3'd5, 3'd2, 2'd1, {6'd0, 6'd38, 6'd36, 6'd35},       3, 2'd1, 1'b1, 1'b1, 2'd0,  9, 4, 6'd38};
      vecs[7] = '{3'd3, 3'd7, 2'd1, 24'd0,                             0, 2'd0, 1'b1, 1'b0, 2'd0,  0, 0, 6'd0};
      vecs[8] = '{3'd2, 3'd2, 2'd0, 24'd0,                             0, 2'd0, 1'b1, 1'b0, 2'd0,  0, 0, 6'd0};
      vecs[9] = '{3'd6, 3'd0, 2'd1, 24'd0,                             0, 2'd0, 1'b0, 1'b0, 2'd0,  0, 0, 6'd0};

      clear_board();
      Resetn = 1'b0; start = 1'b0; row = 3'd0; col = 3'd0; player = 2'd0;
      @(posedge Clock); @(posedge Clock); #1;
      chk("reset.outputs", {rd_en, rd_addr, busy, done, win, win_dir}, 0);
      Resetn = 1'b1;
      @(posedge Clock); #1;

      // reset while waiting on a read
      clear_board();
      row = 3'd5; col = 3'd3; player = 2'd1; start = 1'b1;
      @(posedge Clock); #1;
      start = 1'b0;
      n_wait = 0;
      while (rd_en !== 1'b1 && n_wait < 20) begin
         @(posedge Clock); #1;
         n_wait++;
      end
      chk("rst.first_read_seen", rd_en, 1);
      @(posedge Clock); #1;
      chk("rst.busy_in_wait", busy, 1);
      Resetn = 1'b0;
      #1;
      chk("rst.outputs_drop", {busy, rd_en, done, win}, 0);
      #2 Resetn = 1'b1;
      quiet_ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge Clock); #1;
         if (done !== 1'b0 || busy !== 1'b0) quiet_ok = 1'b0;
      end
      chk("rst.no_done_after_abort", quiet_ok, 1);

      for (int i = 0; i < NV; i++) begin
         clear_board();
         for (int j = 0; j < vecs[i].ncells; j++) board[vecs[i].cells[j*6 +: 6]] = vecs[i].val;
         ref_scan(vecs[i].r, vecs[i].c, vecs[i].p);
         run_scan(vecs[i].r, vecs[i].c, vecs[i].p, vecs[i].dup);
         chk($sformatf("vec%0d.tbl_done_cycle", i), got_cyc, vecs[i].ecyc);
         chk($sformatf("vec%0d.tbl_win", i), got_win, vecs[i].ew);
         if (vecs[i].ew) chk($sformatf("vec%0d.tbl_win_dir", i), got_dir, vecs[i].ed);
         chk($sformatf("vec%0d.tbl_nreads", i), got_q.size(), vecs[i].enrd);
         if (vecs[i].enrd > 0 && got_q.size() > 0)
            chk($sformatf("vec%0d.tbl_first_addr", i), got_q[0], vecs[i].efirst);
         cmp_model($sformatf("vec%0d", i));
      end

      for (int t = 0; t < 150; t++) begin
         r_rnd = 3'($urandom_range(0, 6));
         c_rnd = 3'($urandom_range(0, 7));
         p_rnd = ($urandom_range(0, 11) == 0) ? 2'b00 : 2'($urandom_range(1, 2));
         for (int i = 0; i < 42; i++) begin
            v_rnd = $urandom_range(0, 4);
            board[i] = (v_rnd >= 3) ? p_rnd : 2'(v_rnd);
         end
         ref_scan(r_rnd, c_rnd, p_rnd);
         run_scan(r_rnd, c_rnd, p_rnd, 1'($urandom_range(0, 1)));
         cmp_model($sformatf("rnd%0d", t));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
